inst_encoder: RTL and testbench

- Sequential RV32I instruction encoder: accepts decoded instruction fields (rd, rs1, rs2, imm, alu_op, com_op, encoding kind) over a valid/ready handshake.
- Emits 32-bit instruction words into instruction memory through a write port with backpressure.
- Expands the LI pseudo-instruction into LUI+ADDI when needed.
- Used by the on-chip program loader and by self-test generation; inverse of the core's decode stage.

---
 rtl/enc_pkg.sv | 38 +++
 rtl/inst_enc_fmt.sv | 118 +++++++++++
 rtl/inst_encoder.sv | 131 +++++++++++++
 tb/tb_inst_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and RV32I opcode constants for the instruction encoder.
package enc_pkg;

  typedef enum logic [3:0] {
    K_REG    = 4'd0,
    K_IMM    = 4'd1,
    K_LOAD   = 4'd2,
    K_STORE  = 4'd3,
    K_LUI    = 4'd4,
    K_AUIPC  = 4'd5,
    K_JAL    = 4'd6,
    K_JALR   = 4'd7,
    K_BRANCH = 4'd8,
    K_LI     = 4'd9
  } enc_kind_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT0 = 2'd1,
    ST_EMIT1 = 2'd2
  } state_t;

  // True when v is representable as a signed 12-bit value.
  function automatic logic fits_s12(input logic [31:0] v);
    return (&v[31:11]) | (~|v[31:11]);
  endfunction

endpackage

// File: rtl/inst_enc_fmt.sv
// Combinational RV32I field packer: builds up to two words per request and flags illegal ones.
module inst_enc_fmt
  import enc_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  input  logic [3:0]  alu_op_i,
  input  logic [2:0]  com_op_i,
  output logic        ok_o,
  output logic        two_o,
  output logic [31:0] word0_o,
  output logic [31:0] word1_o
);

  function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] fmt_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], opc};
  endfunction

  function automatic logic [31:0] fmt_u(input logic [19:0] hi, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {hi, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_j(input logic [20:0] off, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {off[20], off[10:1], off[11], off[19:12], rd, opc};
  endfunction

  logic        s12_ok;
  logic        b13_ok;
  logic        j21_ok;
  logic        is_shift;
  logic [11:0] shamt_imm;
  logic [31:0] li_hi_sum;

  assign s12_ok    = fits_s12(imm_i);
  assign b13_ok    = (&imm_i[31:12]) | (~|imm_i[31:12]);
  assign j21_ok    = (&imm_i[31:20]) | (~|imm_i[31:20]);
  assign is_shift  = (alu_op_i[1:0] == 2'b01);
  assign shamt_imm = {1'b0, alu_op_i[3], 5'b0, imm_i[4:0]};
  // Rounding the upper part by 0x800 compensates for ADDI sign-extending the low 12 bits.
  assign li_hi_sum = imm_i + 32'h0000_0800;

  always_comb begin
    ok_o    = 1'b1;
    two_o   = 1'b0;
    word0_o = '0;
    word1_o = '0;
    case (kind_i)
      K_REG: word0_o = fmt_r({1'b0, alu_op_i[3], 5'b0}, rs2_i, rs1_i, alu_op_i[2:0], rd_i, OPC_OP);
      K_IMM: begin
        if (is_shift) begin
          ok_o    = ~|imm_i[31:5];
          word0_o = fmt_i(shamt_imm, rs1_i, alu_op_i[2:0], rd_i, OPC_OP_IMM);
        end else begin
          ok_o    = s12_ok;
          word0_o = fmt_i(imm_i[11:0], rs1_i, alu_op_i[2:0], rd_i, OPC_OP_IMM);
        end
      end
      K_LOAD: begin
        ok_o    = s12_ok;
        word0_o = fmt_i(imm_i[11:0], rs1_i, com_op_i, rd_i, OPC_LOAD);
      end
      K_STORE: begin
        ok_o    = s12_ok;
        word0_o = fmt_s(imm_i[11:0], rs2_i, rs1_i, com_op_i, OPC_STORE);
      end
      K_LUI:   word0_o = fmt_u(imm_i[31:12], rd_i, OPC_LUI);
      K_AUIPC: word0_o = fmt_u(imm_i[31:12], rd_i, OPC_AUIPC);
      K_JAL: begin
        ok_o    = j21_ok & ~imm_i[0];
        word0_o = fmt_j(imm_i[20:0], rd_i, OPC_JAL);
      end
      K_JALR: begin
        ok_o    = s12_ok;
        word0_o = fmt_i(imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR);
      end
      K_BRANCH: begin
        ok_o    = b13_ok & ~imm_i[0];
        word0_o = fmt_b(imm_i[12:0], rs2_i, rs1_i, com_op_i, OPC_BRANCH);
      end
      K_LI: begin
        if (s12_ok) begin
          word0_o = fmt_i(imm_i[11:0], 5'd0, 3'b000, rd_i, OPC_OP_IMM);
        end else begin
          word0_o = fmt_u(li_hi_sum[31:12], rd_i, OPC_LUI);
          two_o   = |imm_i[11:0];
          word1_o = fmt_i(imm_i[11:0], rd_i, 3'b000, rd_i, OPC_OP_IMM);
        end
      end
      default: ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Sequential RV32I encoder: validates a request, then streams one or two words to imem.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic [3:0]        in_alu_op,
  input  logic [2:0]        in_com_op,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       words_written,
  output logic              err,
  output logic              err_sticky
);

  state_t            state_q, state_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word1_q, word1_d;
  logic              two_q, two_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;

  logic        fmt_ok;
  logic        fmt_two;
  logic [31:0] fmt_w0;
  logic [31:0] fmt_w1;

  inst_enc_fmt u_fmt (
    .kind_i   (in_kind),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .alu_op_i (in_alu_op),
    .com_op_i (in_com_op),
    .ok_o     (fmt_ok),
    .two_o    (fmt_two),
    .word0_o  (fmt_w0),
    .word1_o  (fmt_w1)
  );

  logic write_fire;
  assign write_fire = (state_q != ST_IDLE) && mem_ready;

  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    word1_d  = word1_q;
    two_d    = two_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    if (write_fire) begin
      addr_d = addr_q + ADDR_W'(4);
      if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (fmt_ok) begin
            wdata_d = fmt_w0;
            word1_d = fmt_w1;
            two_d   = fmt_two;
            state_d = ST_EMIT0;
          end else begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end
        end
      end
      ST_EMIT0: begin
        if (mem_ready) begin
          if (two_q) begin
            wdata_d = word1_q;
            state_d = ST_EMIT1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMIT1: if (mem_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wdata_q  <= '0;
      word1_q  <= '0;
      two_q    <= 1'b0;
      addr_q   <= BASE_ADDR;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdata_q  <= wdata_d;
      word1_q  <= word1_d;
      two_q    <= two_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign mem_we        = (state_q != ST_IDLE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign words_written = cnt_q;
  assign err           = err_q;
  assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against an arithmetic reference of the RV32I encodings.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_com_op;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_written;
  logic        err;
  logic        err_sticky;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_kind       (in_kind),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .in_alu_op     (in_alu_op),
    .in_com_op     (in_com_op),
    .mem_we        (mem_we),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .words_written (words_written),
    .err           (err),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr;
  int          exp_cnt;
  logic        exp_sticky;
  logic [31:0] last_w [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: kinds 0..9 = REG IMM LOAD STORE LUI AUIPC JAL JALR BRANCH LI.
  function automatic void ref_enc(input int kind, input logic [4:0] rd, rs1, rs2,
                                  input logic [31:0] imm, input logic [3:0] alu,
                                  input logic [2:0] com, output bit ok, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
    int          s;
    logic [31:0] RD, RS1, RS2, F3, CM, hi, lo;
    s   = $signed(imm);
    RD  = 32'(rd) << 7;
    RS1 = 32'(rs1) << 15;
    RS2 = 32'(rs2) << 20;
    F3  = 32'(alu[2:0]) << 12;
    CM  = 32'(com) << 12;
    ok = 1'b1; n = 1; w0 = 0; w1 = 0;
    case (kind)
      0: w0 = (alu[3] ? 32'h4000_0000 : 32'h0) | RS2 | RS1 | F3 | RD | 32'h33;
      1: begin
        if (alu[2:0] == 3'd1 || alu[2:0] == 3'd5) begin
          ok = (imm <= 32'd31);
          w0 = (((alu[3] ? 32'h400 : 32'h0) + imm) << 20) | RS1 | F3 | RD | 32'h13;
        end else begin
          ok = (s >= -2048 && s <= 2047);
          w0 = (imm << 20) | RS1 | F3 | RD | 32'h13;
        end
      end
      2: begin ok = (s >= -2048 && s <= 2047); w0 = (imm << 20) | RS1 | CM | RD | 32'h03; end
      3: begin
        ok = (s >= -2048 && s <= 2047);
        w0 = (((imm >> 5) & 32'h7F) << 25) | RS2 | RS1 | CM | ((imm & 32'h1F) << 7) | 32'h23;
      end
      4: w0 = (imm & 32'hFFFF_F000) | RD | 32'h37;
      5: w0 = (imm & 32'hFFFF_F000) | RD | 32'h17;
      6: begin
        ok = (s >= -1048576 && s <= 1048574 && (s % 2 == 0));
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | RD | 32'h6F;
      end
      7: begin ok = (s >= -2048 && s <= 2047); w0 = (imm << 20) | RS1 | RD | 32'h67; end
      8: begin
        ok = (s >= -4096 && s <= 4094 && (s % 2 == 0));
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | RS2 | RS1 | CM |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      end
      9: begin
        if (s >= -2048 && s <= 2047) begin
          w0 = (imm << 20) | RD | 32'h13;
        end else begin
          hi = (imm + 32'h800) >> 12;
          lo = imm & 32'hFFF;
          w0 = (hi << 12) | RD | 32'h37;
          if (lo != 0) begin
            n  = 2;
            w1 = (lo << 20) | (32'(rd) << 15) | RD | 32'h13;
          end
        end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // stall0 >= 0 forces that many mem_ready-low cycles on the first word; -1 picks randomly.
  task automatic send(input int kind, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                      input logic [3:0] alu, input logic [2:0] com, input int stall0);
    bit          ok;
    int          n;
    int          stalls;
    logic [31:0] w [2];
    ref_enc(kind, rd, rs1, rs2, imm, alu, com, ok, n, w[0], w[1]);
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_err", 32'(err), 32'd0);
    in_kind = 4'(kind); in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_alu_op = alu; in_com_op = com; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_imm   = $urandom;
    in_kind  = 4'($urandom_range(0, 15));
    if (!ok) begin
      exp_sticky = 1'b1;
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_we", 32'(mem_we), 32'd0);
      check("err_addr", mem_addr, exp_addr);
      check("err_sticky", 32'(err_sticky), 32'd1);
    end else begin
      for (int k = 0; k < n; k++) begin
        stalls = (k == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, 2));
        for (int c = 0; c <= stalls; c++) begin
          check("we", 32'(mem_we), 32'd1);
          check("busy_ready", 32'(in_ready), 32'd0);
          check("addr", mem_addr, exp_addr);
          check("wdata", mem_wdata, w[k]);
          check("count", 32'(words_written), 32'(exp_cnt));
          last_w[k] = mem_wdata;
          mem_ready = (c == stalls);
          @(negedge clk);
        end
        mem_ready = 1'b0;
        exp_addr += 32'd4;
        exp_cnt++;
      end
      check("done_we", 32'(mem_we), 32'd0);
      check("done_count", 32'(words_written), 32'(exp_cnt));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_alu_op = '0; in_com_op = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_count", 32'(words_written), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    rst_n = 1'b1;
    exp_addr = BASE; exp_cnt = 0; exp_sticky = 1'b0;

    send(0, 5'd3, 5'd1, 5'd2, 32'd0, 4'b0000, 3'd0, -1);
    check("reg_add_word", last_w[0], 32'h0020_81B3);
    send(0, 5'd3, 5'd1, 5'd2, 32'd0, 4'b1000, 3'd0, -1);
    check("reg_sub_word", last_w[0], 32'h4020_81B3);
    send(1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 4'b0000, 3'd0, -1);
    check("addi_m1_word", last_w[0], 32'hFFF0_0093);
    send(1, 5'd1, 5'd0, 5'd0, 32'd2048, 4'b0000, 3'd0, -1);
    send(9, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 4'b0000, 3'd0, 3);
    check("li_lui_word", last_w[0], 32'h1234_52B7);
    check("li_addi_word", last_w[1], 32'h6782_8293);
    send(9, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 4'b0000, 3'd0, -1);
    check("li_lui_only", last_w[0], 32'h0000_10B7);
    send(9, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 4'b0000, 3'd0, -1);
    check("li_addi_only", last_w[0], 32'h8000_0093);
    send(8, 5'd0, 5'd1, 5'd2, 32'd8, 4'b0000, 3'd0, -1);
    check("beq_word", last_w[0], 32'h0020_8463);
    send(8, 5'd0, 5'd1, 5'd2, 32'd7, 4'b0000, 3'd0, -1);
    send(8, 5'd0, 5'd1, 5'd2, 32'd4094, 4'b0000, 3'd1, -1);
    send(8, 5'd0, 5'd1, 5'd2, 32'd4096, 4'b0000, 3'd1, -1);
    send(8, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 4'b0000, 3'd1, -1);
    send(6, 5'd1, 5'd0, 5'd0, 32'd1048574, 4'b0000, 3'd0, -1);
    send(6, 5'd1, 5'd0, 5'd0, 32'd1048576, 4'b0000, 3'd0, -1);
    send(1, 5'd4, 5'd2, 5'd0, 32'd31, 4'b1101, 3'd0, -1);
    send(1, 5'd4, 5'd2, 5'd0, 32'd32, 4'b0001, 3'd0, -1);
    send(12, 5'd4, 5'd2, 5'd0, 32'd0, 4'b0000, 3'd0, -1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 4))
        0:       imm = $urandom;
        1:       imm = 32'(int'($urandom_range(0, 4200)) - 2100);
        2:       imm = 32'($urandom_range(0, 40));
        3:       imm = 32'(int'($urandom_range(0, 8400)) - 4200);
        default: imm = 32'(int'($urandom_range(0, 2200000)) - 1100000);
      endcase
      send(int'($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom),
           imm, 4'($urandom), 3'($urandom), -1);
    end
    check("sticky_final", 32'(err_sticky), 32'(exp_sticky));

    // Reset while the second LI word is pending.
    @(negedge clk);
    in_kind = 4'd9; in_rd = 5'd7; in_imm = 32'h0ABC_D123; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("pre_rst_we", 32'(mem_we), 32'd1);
    check("pre_rst_addr", mem_addr, exp_addr + 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", mem_addr, BASE);
    check("mid_rst_count", 32'(words_written), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sticky", 32'(err_sticky), 32'd0);
    exp_addr = BASE; exp_cnt = 0; exp_sticky = 1'b0;
    send(5, 5'd9, 5'd0, 5'd0, 32'hDEAD_BEEF, 4'b0000, 3'd0, 1);
    check("auipc_word", last_w[0], 32'hDEAD_B497);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
